sdram_rd_arbiter: RTL and testbench

Burst-granular round-robin arbiter sharing one Avalon-MM SDRAM read port between `N_MASTERS` burst read masters, such as DMA engines and line fetchers. It sits between the read masters and the SDRAM controller slave. It grants one master at a time and holds the grant from command acceptance until the last `readdatavalid` beat of that burst. Only one burst is outstanding at a time.

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_rd_arbiter_rr_pick.sv | 31 +++
 rtl/sdram_rd_arbiter.sv | 131 +++++++++++++
 tb/tb_sdram_rd_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM read-port arbiter.
// Holds the arbiter state encoding and index-width sizing.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE_S = 2'd0,
      CMD_S  = 2'd1,
      DATA_S = 2'd2
   } arb_state_t;

   localparam int MAX_MASTERS = 8;

   // Width of an index into n items; never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sdram_rd_arbiter_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr_i, cyclically.
// Purely combinational, zero latency, no backpressure.
module rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   always_comb begin
      int c;
      c     = 0;
      idx_o = ptr_i;
      any_o = 1'b0;
      // Scan from the farthest offset down so the nearest requester wins.
      for (int i = N - 1; i >= 0; i--) begin
         c = int'(ptr_i) + i;
         if (c >= N) c = c - N;
         if (req_i[c]) begin
            idx_o = IDX_W'(c);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_rd_arbiter.sv
// Burst-granular round-robin arbiter for one Avalon-MM SDRAM read port; grant is
// registered (request->s_read in 1 cycle), command and readdatavalid pass through combinationally.
module sdram_rd_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 27,
   parameter int DATA_W    = 32,
   parameter int BURST_W   = 9
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [N_MASTERS-1:0]           m_read_i,
   input  logic [N_MASTERS*ADDR_W-1:0]    m_address_i,
   input  logic [N_MASTERS*BURST_W-1:0]   m_burstcount_i,
   output logic [N_MASTERS-1:0]           m_waitrequest_o,
   output logic [N_MASTERS-1:0]           m_readdatavalid_o,
   output logic [DATA_W-1:0]              m_readdata_o,
   output logic                           s_read_o,
   output logic [ADDR_W-1:0]              s_address_o,
   output logic [BURST_W-1:0]             s_burstcount_o,
   input  logic                           s_waitrequest_i,
   input  logic                           s_readdatavalid_i,
   input  logic [DATA_W-1:0]              s_readdata_i,
   output logic [$clog2(N_MASTERS)-1:0]   grant_o,
   output logic                           busy_o,
   output logic                           err_o
);

   localparam int GW = $clog2(N_MASTERS);

   arb_state_t         state_q, state_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [GW-1:0]      ptr_q, ptr_d;
   logic [GW-1:0]      pick_idx, grant_inc;
   logic [BURST_W-1:0] beat_q, beat_d;
   logic               err_q, err_d;
   logic               pick_any;
   logic               g_read;
   logic [ADDR_W-1:0]  g_addr;
   logic [BURST_W-1:0] g_bc;

   rr_pick #(
      .N     (N_MASTERS),
      .IDX_W (GW)
   ) u_pick (
      .req_i (m_read_i),
      .ptr_i (ptr_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign g_read    = m_read_i[grant_q];
   assign g_addr    = m_address_i[int'(grant_q)*ADDR_W +: ADDR_W];
   assign g_bc      = m_burstcount_i[int'(grant_q)*BURST_W +: BURST_W];
   assign grant_inc = (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + GW'(1);

   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      ptr_d             = ptr_q;
      beat_d            = beat_q;
      // Data with no burst outstanding is a slave protocol violation.
      err_d             = err_q | (s_readdatavalid_i && (state_q != DATA_S));
      m_waitrequest_o   = '1;
      m_readdatavalid_o = '0;
      s_read_o          = 1'b0;
      s_address_o       = '0;
      s_burstcount_o    = '0;
      case (state_q)
         IDLE_S: begin
            if (pick_any) begin
               grant_d = pick_idx;
               state_d = CMD_S;
            end
         end
         CMD_S: begin
            s_read_o                 = g_read;
            s_address_o              = g_addr;
            s_burstcount_o           = g_bc;
            m_waitrequest_o[grant_q] = s_waitrequest_i;
            // A withdrawn request keeps its turn: the pointer is left alone.
            if (!g_read) begin
               state_d = IDLE_S;
            end else if (!s_waitrequest_i) begin
               if (g_bc == '0) begin
                  err_d   = 1'b1;
                  ptr_d   = grant_inc;
                  state_d = IDLE_S;
               end else begin
                  beat_d  = g_bc;
                  state_d = DATA_S;
               end
            end
         end
         DATA_S: begin
            m_readdatavalid_o[grant_q] = s_readdatavalid_i;
            if (s_readdatavalid_i) begin
               beat_d = beat_q - BURST_W'(1);
               if (beat_q == BURST_W'(1)) begin
                  ptr_d   = grant_inc;
                  state_d = IDLE_S;
               end
            end
         end
         default: state_d = IDLE_S;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE_S;
         grant_q <= '0;
         ptr_q   <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   assign m_readdata_o = s_readdata_i;
   assign grant_o      = grant_q;
   assign busy_o       = (state_q != IDLE_S);
   assign err_o        = err_q;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed bench for sdram_rd_arbiter (3 masters); the bench plays the SDRAM slave and
// a scoreboard queue holds the beats each master should receive.
module tb_sdram_rd_arbiter;

   localparam int N  = 3;
   localparam int AW = 27;
   localparam int DW = 32;
   localparam int BW = 9;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [N-1:0]      m_read;
   logic [N*AW-1:0]   m_addr;
   logic [N*BW-1:0]   m_bc;
   logic [N-1:0]      m_waitrequest_o;
   logic [N-1:0]      m_readdatavalid_o;
   logic [DW-1:0]     m_readdata_o;
   logic              s_read_o;
   logic [AW-1:0]     s_address_o;
   logic [BW-1:0]     s_burstcount_o;
   logic              s_wait;
   logic              s_rdv;
   logic [DW-1:0]     s_rdata;
   logic [1:0]        grant_o;
   logic              busy_o;
   logic              err_o;

   typedef struct packed {
      logic [1:0]  m;
      logic [31:0] d;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   sdram_rd_arbiter #(
      .N_MASTERS (N),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .BURST_W   (BW)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .m_read_i          (m_read),
      .m_address_i       (m_addr),
      .m_burstcount_i    (m_bc),
      .m_waitrequest_o   (m_waitrequest_o),
      .m_readdatavalid_o (m_readdatavalid_o),
      .m_readdata_o      (m_readdata_o),
      .s_read_o          (s_read_o),
      .s_address_o       (s_address_o),
      .s_burstcount_o    (s_burstcount_o),
      .s_waitrequest_i   (s_wait),
      .s_readdatavalid_i (s_rdv),
      .s_readdata_i      (s_rdata),
      .grant_o           (grant_o),
      .busy_o            (busy_o),
      .err_o             (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_sread"}, 64'(s_read_o), 64'd0);
      chk({tag, "_saddr"}, 64'(s_address_o), 64'd0);
      chk({tag, "_sbc"},   64'(s_burstcount_o), 64'd0);
      chk({tag, "_mwait"}, 64'(m_waitrequest_o), 64'h7);
      chk({tag, "_mrdv"},  64'(m_readdatavalid_o), 64'd0);
      chk({tag, "_busy"},  64'(busy_o), 64'd0);
      chk({tag, "_grant"}, 64'(grant_o), 64'd0);
      chk({tag, "_err"},   64'(err_o), 64'd0);
   endtask

   task automatic req(input int m, input int bc);
      m_read[m]         = 1'b1;
      m_addr[m*AW +: AW] = AW'(32'h100 * (m + 1));
      m_bc[m*BW +: BW]   = BW'(bc);
   endtask

   task automatic do_reset();
      m_read = '0;
      s_wait = 1'b1;
      s_rdv  = 1'b0;
      rst_ni = 1'b0;
      #3;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   // Waits for the command, checks it, accepts after nwait waitrequest cycles, then returns bc beats.
   // keep=0 drops the master's request at acceptance; reset pulses before beat n_rst.
   task automatic run_burst(input int m, input int bc, input int nwait, input bit keep,
                            input int exp_k, input int n_rst, input logic [31:0] dbase);
      int   k;
      exp_t e;
      k = 0;
      @(negedge clk_i);
      while (!s_read_o && k < 20) begin
         k++;
         @(negedge clk_i);
      end
      chk("cmd_latency", 64'(k), 64'(exp_k));
      chk("grant",       64'(grant_o), 64'(m));
      chk("busy_cmd",    64'(busy_o), 64'd1);
      chk("s_addr",      64'(s_address_o), 64'(32'h100 * (m + 1)));
      chk("s_bc",        64'(s_burstcount_o), 64'(bc));
      chk("m_wait_hold", 64'(m_waitrequest_o), 64'h7);
      for (int i = 1; i < nwait; i++) @(negedge clk_i);
      @(posedge clk_i);
      #1 s_wait = 1'b0;
      @(negedge clk_i);
      chk("m_wait_grant", 64'(m_waitrequest_o), 64'(3'b111 & ~(3'b001 << m)));
      @(posedge clk_i);
      #1 s_wait = 1'b1;
      if (!keep) m_read[m] = 1'b0;
      for (int i = 0; i < bc; i++) begin
         if (i == n_rst) begin
            rst_ni = 1'b0;
            #1;
            chk_idle("midrst");
            rst_ni = 1'b1;
         end
         s_rdv   = 1'b1;
         s_rdata = dbase + 32'(i);
         if (i < n_rst) begin
            e.m = 2'(m);
            e.d = dbase + 32'(i);
            sb_q.push_back(e);
         end
         @(posedge clk_i);
         #1;
      end
      s_rdv = 1'b0;
   endtask

   // Every forwarded beat must be the next expected one, for the right master only.
   always @(negedge clk_i) begin
      if (m_readdatavalid_o != '0) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rdv", 64'(m_readdatavalid_o), 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("rdv_target", 64'(m_readdatavalid_o), 64'(3'b001 << mon_e.m));
            chk("rdata",      64'(m_readdata_o), 64'(mon_e.d));
         end
      end
   end

   initial begin
      m_read  = '0;
      m_addr  = '0;
      m_bc    = '0;
      s_wait  = 1'b1;
      s_rdv   = 1'b0;
      s_rdata = '0;
      rst_ni  = 1'b0;
      #2;
      chk_idle("reset");
      s_rdata = 32'hCAFE_0001;
      #1 chk("rdata_pass", 64'(m_readdata_o), 64'hCAFE_0001);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Single master, two waitrequest cycles, four beats.
      req(0, 4);
      @(negedge clk_i);
      chk("idle_no_sread", 64'(s_read_o), 64'd0);
      chk("idle_busy",     64'(busy_o), 64'd0);
      run_burst(0, 4, 2, 1'b0, 0, 99, 32'hA0);
      @(negedge clk_i);
      chk("single_idle", 64'(busy_o), 64'd0);
      chk("single_sb",   64'(sb_q.size()), 64'd0);

      // Two masters requesting continuously alternate.
      do_reset();
      req(0, 8);
      req(1, 8);
      run_burst(0, 8, 1, 1'b1, 1, 99, 32'h1000);
      run_burst(1, 8, 1, 1'b1, 1, 99, 32'h2000);
      run_burst(0, 8, 1, 1'b1, 1, 99, 32'h3000);
      run_burst(1, 8, 1, 1'b1, 1, 99, 32'h4000);
      m_read = '0;
      @(negedge clk_i);
      chk("rr_sb", 64'(sb_q.size()), 64'd0);

      // Pointer wrap: serve 1 (ptr->2), then 2 and 0 compete, then 1 and 2 compete.
      do_reset();
      req(1, 2);
      @(negedge clk_i);
      run_burst(1, 2, 1, 1'b0, 0, 99, 32'h5000);
      req(2, 2);
      req(0, 2);
      run_burst(2, 2, 1, 1'b0, 1, 99, 32'h5100);
      run_burst(0, 2, 1, 1'b0, 1, 99, 32'h5200);
      req(1, 2);
      req(2, 2);
      run_burst(1, 2, 1, 1'b0, 1, 99, 32'h5300);
      m_read = '0;

      // Zero-length burst: error, back to idle, pointer advances past master 0.
      do_reset();
      req(0, 0);
      @(negedge clk_i);
      @(posedge clk_i);
      #1 s_wait = 1'b0;
      @(negedge clk_i);
      chk("bc0_sread", 64'(s_read_o), 64'd1);
      chk("bc0_err_pre", 64'(err_o), 64'd0);
      @(posedge clk_i);
      #1 s_wait = 1'b1;
      m_read = '0;
      @(negedge clk_i);
      chk("bc0_err",  64'(err_o), 64'd1);
      chk("bc0_idle", 64'(busy_o), 64'd0);
      repeat (3) @(negedge clk_i);
      chk("bc0_sticky", 64'(err_o), 64'd1);
      req(0, 2);
      req(1, 2);
      run_burst(1, 2, 1, 1'b0, 0, 99, 32'h6000);
      m_read = '0;
      @(negedge clk_i);
      chk("bc0_after_err", 64'(err_o), 64'd1);

      // Stray readdatavalid while idle.
      do_reset();
      chk("stray_err_pre", 64'(err_o), 64'd0);
      s_rdv   = 1'b1;
      s_rdata = 32'hBAD;
      @(negedge clk_i);
      chk("stray_nofwd", 64'(m_readdatavalid_o), 64'd0);
      @(posedge clk_i);
      #1 s_rdv = 1'b0;
      @(negedge clk_i);
      chk("stray_err", 64'(err_o), 64'd1);
      req(2, 3);
      run_burst(2, 3, 1, 1'b0, 0, 99, 32'h7000);
      @(negedge clk_i);
      chk("stray_sticky", 64'(err_o), 64'd1);
      chk("stray_sb", 64'(sb_q.size()), 64'd0);

      // Granted master withdraws before acceptance; it keeps its turn.
      do_reset();
      req(1, 4);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("wd_grant", 64'(grant_o), 64'd1);
      chk("wd_sread", 64'(s_read_o), 64'd1);
      @(posedge clk_i);
      #1 m_read[1] = 1'b0;
      @(negedge clk_i);
      chk("wd_sread_drop", 64'(s_read_o), 64'd0);
      @(negedge clk_i);
      chk("wd_idle", 64'(busy_o), 64'd0);
      req(1, 2);
      req(2, 2);
      run_burst(1, 2, 1, 1'b0, 0, 99, 32'h8000);
      m_read = '0;

      // Reset after 2 of 16 beats: remaining beats are dropped and flagged.
      do_reset();
      req(0, 16);
      run_burst(0, 16, 1, 1'b0, 1, 2, 32'h9000);
      @(negedge clk_i);
      chk("rst_err",  64'(err_o), 64'd1);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("sb_final", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
